// File: rtl/btn_onehot_capture_pkg.sv
// Shared types and helpers for the button capture front end of the 8-to-3 encoder.
// FSM state encoding and the one-hot test live here so the bench and RTL agree.
package btn_onehot_capture_pkg;

    localparam int BIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        MULTI = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [BIT_DEFAULT-1:0] v);
        return (v != '0) &&
               ((v & (v - {{(BIT_DEFAULT-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-bit 2-flop sync plus tick-sampled debounce; db changes only after DEB_SAMPLES equal samples.
// Latency btn->db is 2+(DEB_SAMPLES-1)*DEB_TICKS+1 .. 2+DEB_SAMPLES*DEB_TICKS cycles; no backpressure.
module btn_debounce
    import btn_onehot_capture_pkg::*;
#(
    parameter int BIT         = BIT_DEFAULT,
    parameter int DEB_TICKS   = 50000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [BIT-1:0] btn,
    output logic [BIT-1:0] db
);

    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DEB_TICKS - 1);

    logic [BIT-1:0]         r_s1;
    logic [BIT-1:0]         r_bs;
    logic [CW-1:0]          r_cnt;
    logic [BIT-1:0]         r_db;
    logic [DEB_SAMPLES-1:0] r_sh  [BIT];
    logic [DEB_SAMPLES-1:0] w_nxt [BIT];
    logic                   w_tick;

    assign w_tick = (r_cnt == TICK_LAST);

    // Decide on the window including the sample being shifted in this tick.
    always_comb begin
        for (int k = 0; k < BIT; k++) begin
            w_nxt[k] = {r_sh[k][DEB_SAMPLES-2:0], r_bs[k]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= '0;
            r_bs  <= '0;
            r_cnt <= '0;
            r_db  <= '0;
            for (int k = 0; k < BIT; k++) begin
                r_sh[k] <= '0;
            end
        end else begin
            r_s1  <= btn;
            r_bs  <= r_s1;
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                for (int k = 0; k < BIT; k++) begin
                    r_sh[k] <= w_nxt[k];
                    if (&w_nxt[k]) begin
                        r_db[k] <= 1'b1;
                    end else if (~|w_nxt[k]) begin
                        r_db[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign db = r_db;

endmodule

// File: rtl/btn_onehot_capture.sv
// Debounced single-key capture feeding the encoder; onehot is only ever zero or one-hot.
// db->onehot/press latency 1 cycle; no backpressure, clr wins over a same-cycle latch.
module btn_onehot_capture
    import btn_onehot_capture_pkg::*;
#(
    parameter int BIT         = BIT_DEFAULT,
    parameter int DEB_TICKS   = 50000,
    parameter int DEB_SAMPLES = 4,
    parameter int LATCH       = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [BIT-1:0] btn,
    input  logic           clr,
    output logic [BIT-1:0] onehot,
    output logic           press,
    output logic           multi
);

    logic [BIT-1:0] w_db;
    state_t         r_state;
    logic [BIT-1:0] r_key;
    logic [BIT-1:0] r_onehot;
    logic           r_press;
    logic           r_multi;

    btn_debounce #(
        .BIT        (BIT),
        .DEB_TICKS  (DEB_TICKS),
        .DEB_SAMPLES(DEB_SAMPLES)
    ) u_debounce (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .db (w_db)
    );

    // r_key tracks the physically held key separately from onehot, so a key
    // cleared by clr is not re-latched while it stays down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_key    <= '0;
            r_onehot <= '0;
            r_press  <= 1'b0;
            r_multi  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (is_onehot(w_db)) begin
                        r_state <= HELD;
                        r_key   <= w_db;
                        if (!clr) begin
                            r_onehot <= w_db;
                            r_press  <= 1'b1;
                        end
                    end else if (w_db != '0) begin
                        r_state <= MULTI;
                        r_multi <= 1'b1;
                    end
                end
                HELD: begin
                    if (w_db == r_key) begin
                        r_state <= HELD;
                    end else if (w_db == '0) begin
                        r_state <= IDLE;
                        if (LATCH == 0) r_onehot <= '0;
                    end else if (is_onehot(w_db)) begin
                        r_key <= w_db;
                        if (!clr) begin
                            r_onehot <= w_db;
                            r_press  <= 1'b1;
                        end
                    end else begin
                        r_state <= MULTI;
                        r_multi <= 1'b1;
                        if (LATCH == 0) r_onehot <= '0;
                    end
                end
                MULTI: begin
                    if (w_db == '0) begin
                        r_state <= IDLE;
                        r_multi <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_multi <= 1'b0;
                end
            endcase
            if (clr) r_onehot <= '0;
        end
    end

    assign onehot = r_onehot;
    assign press  = r_press;
    assign multi  = r_multi;

endmodule

// File: tb/tb_btn_onehot_capture.sv
// Directed bench: two instances (LATCH=1 and LATCH=0) share stimulus; DEB_TICKS=4, DEB_SAMPLES=3.
module tb_btn_onehot_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] btn = 8'h00;
    logic [7:0] onehot, onehot0;
    logic       press, press0, multi, multi0;

    int n_checks   = 0;
    int n_errors   = 0;
    int press_cnt  = 0;
    int press0_cnt = 0;

    btn_onehot_capture #(.BIT(8), .DEB_TICKS(4), .DEB_SAMPLES(3), .LATCH(1)) dut (
        .clk(clk), .rst(rst), .btn(btn), .clr(clr),
        .onehot(onehot), .press(press), .multi(multi)
    );

    btn_onehot_capture #(.BIT(8), .DEB_TICKS(4), .DEB_SAMPLES(3), .LATCH(0)) dut0 (
        .clk(clk), .rst(rst), .btn(btn), .clr(clr),
        .onehot(onehot0), .press(press0), .multi(multi0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press)  press_cnt++;
        if (press0) press0_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int base;

        // Reset state
        step(3);
        check("rst_onehot", onehot, 8'h00);
        check("rst_press",  press,  1'b0);
        check("rst_multi",  multi,  1'b0);
        rst = 1'b0;
        step(2);

        // 1: single press, latency window, one-cycle press, latch after release
        base = press_cnt;
        btn  = 8'h04;
        cyc  = 0;
        while (onehot !== 8'h04 && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("t1_onehot", onehot, 8'h04);
        check("t1_lat_in_window", (cyc >= 12 && cyc <= 15), 1'b1);
        check("t1_press_same_cycle", press, 1'b1);
        step(1);
        check("t1_press_one_cycle", press, 1'b0);
        step(40 - cyc);
        check("t1_press_count", press_cnt - base, 1);
        check("t1_multi", multi, 1'b0);
        btn = 8'h00;
        step(30);
        check("t1_latched_after_release", onehot, 8'h04);
        check("t1_no_press_on_release", press_cnt - base, 1);

        // 2: bounce on btn[1] never satisfies 3 equal samples
        base = press_cnt;
        for (int i = 0; i < 10; i++) begin
            btn[1] = ~btn[1];
            step(3);
        end
        check("t2_no_press_bounce", press_cnt - base, 0);
        check("t2_onehot_bounce", onehot, 8'h04);
        btn = 8'h02;
        step(30);
        check("t2_press_after", press_cnt - base, 1);
        check("t2_onehot_after", onehot, 8'h02);
        btn = 8'h00;
        step(30);

        // 3: multi-key handling
        base = press_cnt;
        btn  = 8'h01;
        step(30);
        check("t3_onehot_01", onehot, 8'h01);
        btn = 8'h81;
        step(30);
        check("t3_multi_set", multi, 1'b1);
        check("t3_onehot_kept", onehot, 8'h01);
        btn = 8'h01;
        step(30);
        check("t3_still_multi", multi, 1'b1);
        check("t3_no_relatch", press_cnt - base, 1);
        btn = 8'h00;
        step(30);
        check("t3_multi_clear", multi, 1'b0);
        check("t3_state_idle", dut.r_state, 2'd0);

        // 4: LATCH=0 clears one cycle after db clears
        base = press0_cnt;
        btn  = 8'h10;
        step(30);
        check("t4_onehot0_10", onehot0, 8'h10);
        check("t4_press0", press0_cnt - base, 1);
        btn = 8'h00;
        cyc = 0;
        while (dut0.w_db !== 8'h00 && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("t4_db_cleared", dut0.w_db, 8'h00);
        check("t4_onehot0_held", onehot0, 8'h10);
        step(1);
        check("t4_onehot0_cleared", onehot0, 8'h00);
        check("t4_latch1_kept", onehot, 8'h10);
        step(30);

        // 5: clr coincident with latch
        base = press_cnt;
        btn  = 8'h08;
        cyc  = 0;
        while (dut.w_db !== 8'h08 && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("t5_db_08", dut.w_db, 8'h08);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("t5_onehot_clr", onehot, 8'h00);
        check("t5_press_suppressed", press, 1'b0);
        step(30);
        check("t5_held_no_latch", onehot, 8'h00);
        check("t5_held_no_press", press_cnt - base, 0);
        btn = 8'h00;
        step(30);
        btn = 8'h08;
        step(30);
        check("t5_repress_onehot", onehot, 8'h08);
        check("t5_repress_press", press_cnt - base, 1);

        // 6: reset while latched and held
        btn = 8'h20;
        step(30);
        check("t6_onehot_20", onehot, 8'h20);
        rst = 1'b1;
        #1;
        check("t6_rst_onehot", onehot, 8'h00);
        check("t6_rst_press",  press,  1'b0);
        check("t6_rst_multi",  multi,  1'b0);
        step(3);
        base = press_cnt;
        rst  = 1'b0;
        check("t6_db_zero_after_rst", dut.w_db, 8'h00);
        cyc = 0;
        while (press !== 1'b1 && cyc < 30) begin
            step(1);
            cyc++;
        end
        check("t6_press_seen", press, 1'b1);
        check("t6_press_after_debounce", (cyc >= 12 && cyc <= 15), 1'b1);
        check("t6_onehot_relatched", onehot, 8'h20);
        step(5);
        check("t6_press_count", press_cnt - base, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/btn_onehot_capture.md
Name: btn_onehot_capture

Overview:
Upstream stage of the 8-to-3 one-hot encoder. Takes 8 raw push-button inputs, synchronises and debounces them, and detects single-key presses. Presents a registered, clean one-hot vector on onehot, which drives the encoder's i input directly. When onehot is all-zero, the encoder reports valid=0.

Parameters:
BIT, 8, number of buttons and onehot width; fixed at 8 to match the encoder.
DEB_TICKS, 50000, clock cycles per debounce sample (>=1); value 1 means sample every cycle.
DEB_SAMPLES, 4, consecutive equal samples needed to change a debounced bit (>=2).
LATCH, 1, 1 = keep the last key on onehot after release; 0 = clear onehot on release.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
btn  input  BIT  raw, asynchronous button levels; 1 = pressed
clr  input  1  synchronous clear of the latched key
onehot  output  BIT  registered one-hot key, or all-zero; feeds encoder i
press  output  1  one-cycle pulse when a new single key is latched onto onehot
multi  output  1  level; more than one debounced key is down

Behaviour:
- Reset (async, rst=1): all registers go to 0. This covers the sync flops, tick counter, sample shift registers, debounced vector db, the FSM (to IDLE), onehot, press and multi.
- Sync: 2-flop synchroniser per bit, btn -> bs.
- Tick counter:
  - Width $clog2(DEB_TICKS), minimum 1 bit.
  - Counts 0..DEB_TICKS-1 and wraps to 0.
  - tick=1 in the cycle the count equals DEB_TICKS-1.
- Debounce, per bit, on tick:
  - Shift bs[k] into a DEB_SAMPLES-deep register.
  - db[k] becomes 1 when all samples are 1 and becomes 0 when all samples are 0; otherwise db[k] holds.
- FSM states (2-bit encoding): IDLE, HELD, MULTI. Evaluated every cycle on db.
  - IDLE:
    - db==0: stay.
    - db one-hot: go to HELD; onehot<=db; press<=1.
    - db has >1 bit set: go to MULTI; multi<=1.
  - HELD:
    - db==key: stay.
    - db==0: go to IDLE; if LATCH=0, onehot<=0.
    - db a different single key: new press; onehot<=db; press<=1; stay in HELD.
    - db has >1 bit set: go to MULTI; multi<=1; if LATCH=0, onehot<=0.
  - MULTI:
    - onehot is never updated.
    - Stays in MULTI until db==0, then goes to IDLE with multi<=0.
    - Passing through a single key while leaving MULTI does not latch it.
- press is 1 for exactly one cycle per latch. It asserts in the same cycle onehot takes the new value.
- Latency:
  - db -> onehot/press: 1 cycle.
  - btn edge -> db: between 2+(DEB_SAMPLES-1)*DEB_TICKS+1 and 2+DEB_SAMPLES*DEB_TICKS cycles.
- clr:
  - onehot<=0 in any state.
  - clr takes priority over a latch in the same cycle: press is suppressed and onehot stays 0.
  - The FSM state still advances normally.
  - If the key is still held, it is not re-latched; it must be released and pressed again.
- Output guarantee: onehot is only ever all-zero or exactly one-hot. It never carries a multi-bit value.
- Reset mid-operation: immediate return to reset values, including mid-debounce and mid-tick. No press is issued on exit from reset, even if a key is held; that key latches only after it debounces from 0.

Decomposition:
- Shared package:
  - FSM state constants IDLE=2'd0, HELD=2'd1, MULTI=2'd2.
  - is_onehot function (v!=0 && (v&(v-1))==0).
  - Default BIT=8.
- One sub-module: btn_debounce.
  - Contains the synchroniser, shared tick counter and per-bit sample registers.
  - Parameters BIT, DEB_TICKS, DEB_SAMPLES.
  - Ports clk, rst, btn, db.
- The top level holds the FSM and output registers.

Test Plan:
(All with DEB_TICKS=4, DEB_SAMPLES=3, LATCH=1 unless stated.)
1. Press btn=8'h04 and hold 40 cycles -> db rises within 15 cycles; onehot=8'h04; press high exactly 1 cycle; multi=0. Release -> onehot stays 8'h04 and no further press.
2. Bounce: btn[1] toggles every 3 cycles for 30 cycles, then holds 1 -> no press during bounce; single press afterwards with onehot=8'h02.
3. btn=8'h01, then btn=8'h81 while held -> multi=1, onehot stays 8'h01. Release 8'h80 only -> no latch of 8'h01. Release all -> multi=0, state IDLE.
4. LATCH=0: press 8'h10 then release -> onehot 8'h10 then 8'h00 one cycle after db clears.
5. clr asserted in the same cycle db becomes 8'h08 -> onehot=8'h00, press=0. Key kept held -> no latch. Release and re-press -> onehot=8'h08 with press.
6. Assert rst while 8'h20 is latched and held -> all outputs 0 immediately. Deassert with key still held -> press only after db goes 0 and then 1 again.
